// File: rtl/rtc_pkg.sv
// Shared time-of-day types and limits for the RTC counter and its alarm channels.
package rtc_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;
    localparam int ORE_W         = 5;
    localparam int MIN_W         = 6;

    typedef struct packed {
        logic [ORE_W-1:0] ore;
        logic [MIN_W-1:0] minute;
    } hm_t;

    // True when the value names a real wall-clock time (00:00 .. 23:59).
    function automatic logic hm_valid(input hm_t t);
        return (t.ore < ORE_W'(HOURS_PER_DAY)) && (t.minute < MIN_W'(MIN_PER_HOUR));
    endfunction

endpackage

// File: rtl/rtc_alarm_slot.sv
// One alarm channel: stored time/enable, match compare on minute advances,
// a one-cycle match pulse and a sticky hit flag.
module rtc_alarm_slot
    import rtc_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_we,
    input  hm_t  i_wr_time,
    input  logic i_wr_en,
    input  logic i_clr,
    input  logic i_adv,
    input  hm_t  i_new_time,
    output logic o_pulse,
    output logic o_hit
);

    hm_t  r_alarm;
    logic r_en;
    logic r_pulse;
    logic r_hit;
    logic w_match;

    // Compare uses the stored value, so a write on an advance edge affects only later minutes.
    assign w_match = i_adv && r_en && hm_valid(r_alarm) && (r_alarm == i_new_time);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alarm <= '0;
            r_en    <= 1'b0;
            r_pulse <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_pulse <= w_match;
            if (w_match) begin
                r_hit <= 1'b1;
            end else if (i_clr) begin
                r_hit <= 1'b0;
            end
            if (i_we) begin
                r_alarm <= i_wr_time;
                r_en    <= i_wr_en;
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_hit   = r_hit;

endmodule

// File: rtl/rtc_alarm_counter.sv
// Time-of-day counter (hh:mm) with programmable prescaler, prioritised range-checked
// load ports, minute/day event pulses and N minute-resolution alarm channels.
module rtc_alarm_counter
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_MIN = 64,
    parameter int N_ALARMS      = 2,
    parameter int PS_W          = $clog2(TICKS_PER_MIN),
    parameter int IDX_W         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick_en,
    input  logic                load_1,
    input  logic [ORE_W-1:0]    timp_ore1,
    input  logic [MIN_W-1:0]    timp_minute1,
    input  logic                load_2,
    input  logic [ORE_W-1:0]    timp_ore2,
    input  logic [MIN_W-1:0]    timp_minute2,
    input  logic                alarm_we,
    input  logic [IDX_W-1:0]    alarm_idx,
    input  logic [ORE_W-1:0]    alarm_ore,
    input  logic [MIN_W-1:0]    alarm_minute,
    input  logic                alarm_en,
    input  logic [N_ALARMS-1:0] alarm_clr,
    output logic [ORE_W-1:0]    ore,
    output logic [MIN_W-1:0]    minute,
    output logic                minute_tick,
    output logic                day_tick,
    output logic                load_err,
    output logic [N_ALARMS-1:0] alarm_pulse,
    output logic [N_ALARMS-1:0] alarm_hit
);

    logic [PS_W-1:0] r_ps;
    hm_t             r_time;
    logic            r_minute_tick;
    logic            r_day_tick;
    logic            r_load_err;

    hm_t  w_load_time;
    logic w_load_any;
    logic w_load_ok;
    logic w_ps_term;
    logic w_adv;
    logic w_day_wrap;
    hm_t  w_next_time;
    hm_t  w_alarm_wr_time;

    // load_1 wins outright; an invalid load_1 does not fall back to load_2.
    assign w_load_any  = load_1 | load_2;
    assign w_load_time = load_1 ? hm_t'{ore: timp_ore1, minute: timp_minute1}
                                : hm_t'{ore: timp_ore2, minute: timp_minute2};
    assign w_load_ok   = hm_valid(w_load_time);

    assign w_ps_term  = (r_ps == PS_W'(TICKS_PER_MIN - 1));
    assign w_adv      = !w_load_any && tick_en && w_ps_term;
    assign w_day_wrap = (r_time.ore == ORE_W'(HOURS_PER_DAY - 1)) &&
                        (r_time.minute == MIN_W'(MIN_PER_HOUR - 1));

    always_comb begin
        w_next_time = r_time;
        if (r_time.minute == MIN_W'(MIN_PER_HOUR - 1)) begin
            w_next_time.minute = '0;
            if (r_time.ore == ORE_W'(HOURS_PER_DAY - 1)) begin
                w_next_time.ore = '0;
            end else begin
                w_next_time.ore = r_time.ore + ORE_W'(1);
            end
        end else begin
            w_next_time.minute = r_time.minute + MIN_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ps          <= '0;
            r_time        <= '0;
            r_minute_tick <= 1'b0;
            r_day_tick    <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_minute_tick <= 1'b0;
            r_day_tick    <= 1'b0;
            r_load_err    <= 1'b0;
            if (w_load_any) begin
                if (w_load_ok) begin
                    r_time <= w_load_time;
                    r_ps   <= '0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (tick_en) begin
                if (w_ps_term) begin
                    r_ps          <= '0;
                    r_time        <= w_next_time;
                    r_minute_tick <= 1'b1;
                    r_day_tick    <= w_day_wrap;
                end else begin
                    r_ps <= r_ps + PS_W'(1);
                end
            end
        end
    end

    assign ore         = r_time.ore;
    assign minute      = r_time.minute;
    assign minute_tick = r_minute_tick;
    assign day_tick    = r_day_tick;
    assign load_err    = r_load_err;

    assign w_alarm_wr_time = hm_t'{ore: alarm_ore, minute: alarm_minute};

    // Indices with no matching channel simply select nothing.
    for (genvar k = 0; k < N_ALARMS; k++) begin : g_slot
        logic w_we;
        assign w_we = alarm_we && (alarm_idx == IDX_W'(k));

        rtc_alarm_slot u_slot (
            .clock      (clock),
            .reset      (reset),
            .i_we       (w_we),
            .i_wr_time  (w_alarm_wr_time),
            .i_wr_en    (alarm_en),
            .i_clr      (alarm_clr[k]),
            .i_adv      (w_adv),
            .i_new_time (w_next_time),
            .o_pulse    (alarm_pulse[k]),
            .o_hit      (alarm_hit[k])
        );
    end

endmodule
